// File: rtl/truth_table_sequencer.sv
// Truth-table self-test sequencer: on a start edge, walks every input vector onto
// the gate under test, lets each settle, samples the gate output and compares it
// with the EXPECT table. It reports a mismatch count, the first failing vector and
// a pass flag.
module truth_table_sequencer #(
  parameter int                  NIN    = 2,
  parameter int                  SETTLE = 4,
  parameter logic [2**NIN-1:0]   EXPECT = 4'b0001
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           dut_out,
  output logic [NIN-1:0] dut_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_count,
  output logic [NIN-1:0] fail_idx
);

  // The settle counter needs at least one bit, even when SETTLE == 1.
  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
  localparam logic [NIN-1:0] VEC_LAST = {NIN{1'b1}};
  localparam logic [NIN-1:0] VEC_ONE  = NIN'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [NIN:0]   ERR_ONE  = (NIN+1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE_ST, CHECK, DONE} state_t;

  state_t         state_q, state_d;
  logic           start_q;
  logic [NIN-1:0] vec_q, vec_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NIN:0]   err_q, err_d;
  logic [NIN-1:0] fail_q, fail_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           start_rise;
  logic           mismatch;
  logic [NIN:0]   err_next;

  assign start_rise = start & ~start_q;

  // State and result registers. Reset clears everything so a mid-run abort keeps nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic. A start edge is honoured only in IDLE and DONE, so a run can't be restarted.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fail_d   = fail_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mismatch = (dut_out != EXPECT[vec_q]);
    err_next = mismatch ? (err_q + ERR_ONE) : err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = SETTLE_ST;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SETTLE_ST: begin
        // Hold the vector for exactly SETTLE cycles. The gate output is ignored here.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        err_d = err_next;
        if (mismatch && (err_q == '0)) fail_d = vec_q;
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          vec_d   = vec_q + VEC_ONE;
          state_d = SETTLE_ST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in    = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with NIN=2, SETTLE=4 and a NOR table.
// The gate under test is modelled here, and its behaviour is chosen per run.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       dut_out;
  logic [1:0] dut_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_idx;

  // Gate models: 0 NOR, 1 stuck-0, 2 OR, 3 NOR with swapped inputs, 4 NOT of MSB input
  int   mode = 0;
  logic glitch = 1'b0;
  logic y;

  int checks = 0;
  int fails  = 0;

  truth_table_sequencer #(.NIN(2), .SETTLE(4), .EXPECT(4'b0001)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    y = 1'b0;
    case (mode)
      0: y = ~(dut_in[1] | dut_in[0]);
      1: y = 1'b0;
      2: y = dut_in[1] | dut_in[0];
      3: y = ~(dut_in[0] | dut_in[1]);
      4: y = ~dut_in[1];
      default: y = 1'b0;
    endcase
  end
  assign dut_out = y ^ glitch;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise start and follow a whole run. Checks dut_in on every cycle, and the results at k+20.
  // With tog set, start is toggled while busy. With glt set, dut_out is inverted during settle.
  task automatic run(input string tag, input logic tog, input logic glt,
                     input int exp_err, input int exp_fail, input logic exp_pass);
    start = 1'b1;
    tick(1);
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_pass0"}, pass, 0);
    chk({tag, "_err0"}, err_count, 0);
    for (int m = 0; m < 20; m++) begin
      chk({tag, "_dutin"}, dut_in, m / 5);
      chk({tag, "_notdone"}, done, 0);
      if (tog && m >= 2 && m < 8) start = ~start;
      glitch = glt && ((m % 5) != 4);
      tick(1);
    end
    glitch = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_fidx"}, fail_idx, exp_fail);
    chk({tag, "_dutin_hold"}, dut_in, 3);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fidx", fail_idx, 0);
    chk("rst_dutin", dut_in, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", busy, 0);
    chk("idle_dutin", dut_in, 0);

    // 1: correct NOR gate
    mode = 0; run("nor", 1'b0, 1'b0, 0, 0, 1'b1);
    start = 1'b0; tick(2);
    // 2: gate stuck at 0, so only vector 0 fails
    mode = 1; run("stuck0", 1'b0, 1'b0, 1, 0, 1'b0);
    start = 1'b0; tick(2);
    // 3: OR gate fails every vector. NOR with swapped inputs still passes.
    mode = 2; run("or", 1'b0, 1'b0, 4, 0, 1'b0);
    start = 1'b0; tick(2);
    mode = 3; run("swap", 1'b0, 1'b0, 0, 0, 1'b1);
    start = 1'b0; tick(2);
    // NOT of the MSB input: only vector 1 disagrees with NOR
    mode = 4; run("nota", 1'b0, 1'b0, 1, 1, 1'b0);
    start = 1'b0; tick(2);
    // Glitches during settle must not be counted
    mode = 0; run("glitch", 1'b0, 1'b1, 0, 0, 1'b1);
    start = 1'b0; tick(2);

    // 4: start held high. Exactly one run, and the results stay put.
    mode = 1; run("hold", 1'b0, 1'b0, 1, 0, 1'b0);
    tick(30);
    chk("hold_busy", busy, 0);
    chk("hold_done", done, 1);
    chk("hold_err", err_count, 1);
    start = 1'b0; tick(2);
    mode = 1; run("rerun", 1'b0, 1'b0, 1, 0, 1'b0);
    start = 1'b0; tick(2);

    // 5: start toggled while busy
    mode = 0; run("toggle", 1'b1, 1'b0, 0, 0, 1'b1);
    start = 1'b0; tick(2);

    // 6: reset mid-run while dut_in == 2
    mode = 2;
    start = 1'b1;
    tick(11);
    chk("abort_pre", dut_in, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_dutin", dut_in, 0);
    chk("abort_err", err_count, 0);
    chk("abort_done", done, 0);
    start = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("abort_idle", busy, 0);
    mode = 0; run("after", 1'b0, 1'b0, 0, 0, 1'b1);
    start = 1'b0; tick(2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
